// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg
// Shared types and constants for the stereo PDM transmitter.
//   PCM_W      : width of the signed PCM samples
//   ACC_W      : modulator accumulator width (two guard bits over PCM_W)
//   FS         : full-scale feedback value, 2^(PCM_W-1)
//   pcm_t      : one signed PCM sample
//   acc_t      : signed modulator accumulator
//   pcm_pair_t : left/right sample pair moved through staging and active
// ---------------------------------------------------------------------------
package pdm_pkg;

  localparam int PCM_W = 16;
  localparam int ACC_W = PCM_W + 2;

  typedef logic signed [PCM_W-1:0] pcm_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t FS = acc_t'(1) << (PCM_W - 1);

  typedef struct packed {
    pcm_t left;
    pcm_t right;
  } pcm_pair_t;

  // Widen a PCM sample to accumulator width, keeping its sign.
  function automatic acc_t sign_extend(input pcm_t x);
    return acc_t'(x);
  endfunction

endpackage

// File: rtl/sigma_delta_mod.sv
// ---------------------------------------------------------------------------
// sigma_delta_mod
// First-order sigma-delta modulator for one PDM channel.
//   clk     : system clock
//   rst     : asynchronous active-high reset, clears the accumulator
//   step    : advance the modulator by one PDM bit this cycle
//   clear   : synchronous clear of the accumulator (run control off)
//   x       : signed input sample held for the whole window
//   bit_out : current output bit, 1 when the accumulator is non-negative;
//             this is the bit produced by the next step
// ---------------------------------------------------------------------------
module sigma_delta_mod
  import pdm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic clear,
  input  pcm_t x,
  output logic bit_out
);

  acc_t acc_q;
  acc_t acc_d;

  // The output bit is just the sign of the accumulator, so a step emits
  // the bit for the current state and then subtracts the matching
  // feedback. With |x| <= FS the accumulator stays inside +/-2*FS, which
  // the two guard bits cover without saturation.
  assign bit_out = ~acc_q[ACC_W-1];

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_q + sign_extend(x) - (bit_out ? FS : -FS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/stereo_pdm_tx.sv
// ---------------------------------------------------------------------------
// stereo_pdm_tx
// Two-channel PDM transmitter: generates mic_clk and drives one shared data
// line, left bit while mic_clk is high, right bit while it is low.
//   s_clk     : system clock
//   rst       : asynchronous active-high reset
//   enable    : run control; low stops mic_clk and clears the modulators
//   pcm_left  : signed left sample
//   pcm_right : signed right sample
//   pcm_valid : a PCM pair is offered
//   pcm_ready : staging register is empty; pair taken on valid && ready
//   mic_clk   : generated PDM clock, s_clk / (2*CLK_DIV)
//   mic_data  : shared PDM data line
//   underrun  : one-cycle pulse when a window ends with no pair available
// Parameters: CLK_DIV (4..255) s_clk cycles per half period,
//             OSR (2..1024) mic_clk periods per PCM pair.
// ---------------------------------------------------------------------------
module stereo_pdm_tx
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int OSR     = 64
) (
  input  logic                    s_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [PCM_W-1:0] pcm_left,
  input  logic signed [PCM_W-1:0] pcm_right,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    mic_clk,
  output logic                    mic_data,
  output logic                    underrun
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [9:0] BIT_LAST  = 10'(OSR - 1);

  logic [7:0] half_cnt_q, half_cnt_d;
  logic [9:0] bit_cnt_q, bit_cnt_d;
  logic       mic_clk_q, mic_clk_d;
  logic       mic_data_q, mic_data_d;
  logic       underrun_q, underrun_d;
  logic       stage_full_q, stage_full_d;
  pcm_pair_t  active_q, active_d;
  pcm_pair_t  stage_q, stage_d;

  pcm_pair_t  in_pair;
  logic       toggle;
  logic       rise;
  logic       fall;
  logic       boundary;
  logic       accept;
  logic       left_bit;
  logic       right_bit;

  assign in_pair = '{left: pcm_left, right: pcm_right};

  // A toggle happens on the last count of each half period. Its direction
  // comes from the current mic_clk level, and the window ends on the
  // falling toggle that closes period OSR-1.
  assign toggle   = enable && (half_cnt_q == HALF_LAST);
  assign rise     = toggle && !mic_clk_q;
  assign fall     = toggle && mic_clk_q;
  assign boundary = fall && (bit_cnt_q == BIT_LAST);
  assign accept   = pcm_valid && !stage_full_q;

  assign pcm_ready = !stage_full_q;
  assign mic_clk   = mic_clk_q;
  assign mic_data  = mic_data_q;
  assign underrun  = underrun_q;

  // Left modulator steps on rising toggles, right on falling toggles. On
  // the boundary fall the right step still sees the old active pair,
  // because the new pair is only registered at that same edge.
  sigma_delta_mod u_left_mod (
    .clk     (s_clk),
    .rst     (rst),
    .step    (rise),
    .clear   (!enable),
    .x       (active_q.left),
    .bit_out (left_bit)
  );

  sigma_delta_mod u_right_mod (
    .clk     (s_clk),
    .rst     (rst),
    .step    (fall),
    .clear   (!enable),
    .x       (active_q.right),
    .bit_out (right_bit)
  );

  // Clock divider, period counter and data mux. The data line is loaded
  // in the same cycle as the mic_clk toggle so it is stable for the whole
  // following half period.
  always_comb begin
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    mic_clk_d  = mic_clk_q;
    mic_data_d = mic_data_q;
    if (!enable) begin
      half_cnt_d = '0;
      bit_cnt_d  = '0;
      mic_clk_d  = 1'b0;
      mic_data_d = 1'b0;
    end else begin
      if (toggle) begin
        half_cnt_d = '0;
        mic_clk_d  = !mic_clk_q;
      end else begin
        half_cnt_d = half_cnt_q + 8'd1;
      end
      if (rise) begin
        mic_data_d = left_bit;
      end
      if (fall) begin
        mic_data_d = right_bit;
        bit_cnt_d  = boundary ? '0 : bit_cnt_q + 10'd1;
      end
    end
  end

  // Framing: at a boundary the staged pair wins, then a pair offered in
  // that very cycle, otherwise the active pair repeats and underrun fires.
  // Off the boundary an accepted pair lands in staging.
  always_comb begin
    active_d     = active_q;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    underrun_d   = 1'b0;
    if (boundary) begin
      if (stage_full_q) begin
        active_d     = stage_q;
        stage_full_d = 1'b0;
      end else if (pcm_valid) begin
        active_d = in_pair;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (accept) begin
      stage_d      = in_pair;
      stage_full_d = 1'b1;
    end
  end

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      half_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      mic_clk_q    <= 1'b0;
      mic_data_q   <= 1'b0;
      underrun_q   <= 1'b0;
      stage_full_q <= 1'b0;
      active_q     <= '0;
      stage_q      <= '0;
    end else begin
      half_cnt_q   <= half_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      mic_clk_q    <= mic_clk_d;
      mic_data_q   <= mic_data_d;
      underrun_q   <= underrun_d;
      stage_full_q <= stage_full_d;
      active_q     <= active_d;
      stage_q      <= stage_d;
    end
  end

endmodule

// File: tb/tb_stereo_pdm_tx.sv
// ---------------------------------------------------------------------------
// tb_stereo_pdm_tx
// Self-checking bench for stereo_pdm_tx with CLK_DIV=4 and OSR=64.
// ---------------------------------------------------------------------------
module tb_stereo_pdm_tx;

  localparam int CLK_DIV = 4;
  localparam int OSR     = 64;
  localparam int FS      = 32768;

  logic               s_clk     = 1'b0;
  logic               rst       = 1'b1;
  logic               enable    = 1'b1;
  logic signed [15:0] pcm_left  = '0;
  logic signed [15:0] pcm_right = '0;
  logic               pcm_valid = 1'b0;
  logic               pcm_ready;
  logic               mic_clk;
  logic               mic_data;
  logic               underrun;

  int checks = 0;
  int errors = 0;

  // Model state: enabled-edge count since the last restart, integer
  // accumulators, the active and staged pairs, and expected outputs.
  int kEn = 0;
  int accL = 0, accR = 0;
  int actL = 0, actR = 0, stgL = 0, stgR = 0;
  bit stgFull = 1'b0;
  bit expClk = 1'b0, expData = 1'b0, expUnder = 1'b0, expReady = 1'b1;
  bit mRise = 1'b0, mFall = 1'b0, mBound = 1'b0, mAccept = 1'b0, mRestart = 1'b0;

  // Observed per-window counts of ones taken from the DUT data line.
  int winL = 0, winR = 0;
  int winLQ[$];
  int winRQ[$];
  int underrunCnt = 0;
  bit compareOn = 1'b0;

  stereo_pdm_tx #(
    .CLK_DIV (CLK_DIV),
    .OSR     (OSR)
  ) dut (
    .s_clk     (s_clk),
    .rst       (rst),
    .enable    (enable),
    .pcm_left  (pcm_left),
    .pcm_right (pcm_right),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .mic_clk   (mic_clk),
    .mic_data  (mic_data),
    .underrun  (underrun)
  );

  // 10 ns system clock.
  always #5 s_clk = ~s_clk;

  // One comparison: count it and report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the PCM handshake inputs.
  task automatic applyStimulus(input bit v, input int l, input int r);
    pcm_valid = v;
    pcm_left  = 16'(l);
    pcm_right = 16'(r);
  endtask

  // Advance n system clocks; inputs change 2 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge s_clk);
      #2;
    end
  endtask

  // Advance until the model reports a window boundary, bounded.
  task automatic waitBoundary(input string name);
    int budget;
    budget = 0;
    tick(1);
    while (!mBound && budget < 2000) begin
      tick(1);
      budget++;
    end
    if (!mBound) checkOutput(name, 0, 1);
  endtask

  function automatic int pairL(input int i);
    return i * 3000 - 7000;
  endfunction

  function automatic int pairR(input int i);
    return 5000 - i * 2500;
  endfunction

  task automatic modelReset();
    kEn = 0; accL = 0; accR = 0;
    actL = 0; actR = 0; stgL = 0; stgR = 0; stgFull = 1'b0;
    expClk = 1'b0; expData = 1'b0; expUnder = 1'b0; expReady = 1'b1;
    mRise = 1'b0; mFall = 1'b0; mBound = 1'b0; mAccept = 1'b0; mRestart = 1'b1;
  endtask

  // Timing comes straight from the count of enabled edges: toggle number
  // m = k/CLK_DIV lands on multiples of CLK_DIV, odd m rises, even m falls,
  // and m/2 completed periods divisible by OSR mark a window end.
  task automatic modelStep();
    int  m;
    bit  y;
    int  inL, inR;
    inL = pcm_left;
    inR = pcm_right;
    mRise = 1'b0; mFall = 1'b0; mBound = 1'b0; mAccept = 1'b0; mRestart = 1'b0;
    expUnder = 1'b0;
    if (!enable) begin
      kEn = 0; accL = 0; accR = 0;
      expClk = 1'b0; expData = 1'b0; mRestart = 1'b1;
      if (pcm_valid && !stgFull) begin
        stgL = inL; stgR = inR; stgFull = 1'b1; mAccept = 1'b1;
      end
    end else begin
      kEn++;
      if (kEn % CLK_DIV == 0) begin
        m = kEn / CLK_DIV;
        if (m % 2 == 1) begin
          y = (accL >= 0);
          accL = accL + actL - (y ? FS : -FS);
          expData = y; expClk = 1'b1; mRise = 1'b1;
        end else begin
          y = (accR >= 0);
          accR = accR + actR - (y ? FS : -FS);
          expData = y; expClk = 1'b0; mFall = 1'b1;
          if ((m / 2) % OSR == 0) mBound = 1'b1;
        end
      end
      if (mBound) begin
        if (stgFull) begin
          actL = stgL; actR = stgR; stgFull = 1'b0;
        end else if (pcm_valid) begin
          actL = inL; actR = inR; mAccept = 1'b1;
        end else begin
          expUnder = 1'b1;
        end
      end else if (pcm_valid && !stgFull) begin
        stgL = inL; stgR = inR; stgFull = 1'b1; mAccept = 1'b1;
      end
    end
    expReady = !stgFull;
  endtask

  // The model advances on every clock edge and resets with rst, in the
  // same way the DUT sees them.
  initial begin
    forever begin
      @(posedge s_clk or posedge rst);
      if (rst) modelReset();
      else modelStep();
    end
  end

  // Every falling edge: compare all outputs with the model and tally the
  // DUT's left/right ones per window plus underrun pulses.
  always @(negedge s_clk) begin
    if (compareOn) begin
      checkOutput("mic_clk", mic_clk, expClk);
      checkOutput("mic_data", mic_data, expData);
      checkOutput("pcm_ready", pcm_ready, expReady);
      checkOutput("underrun", underrun, expUnder);
      if (mRestart) begin
        winL = 0;
        winR = 0;
      end
      if (mRise) winL += int'(mic_data);
      if (mFall) winR += int'(mic_data);
      if (mBound) begin
        winLQ.push_back(winL);
        winRQ.push_back(winR);
        winL = 0;
        winR = 0;
      end
      if (underrun === 1'b1) underrunCnt++;
    end
  end

  // Directed scenario sequence.
  initial begin
    int pairIdx;
    int hsCount;
    int bounds;
    int budget;
    int urBefore;

    applyStimulus(0, 0, 0);
    tick(2);
    compareOn = 1'b1;
    tick(3);
    checkOutput("rst_mic_clk", mic_clk, 0);
    checkOutput("rst_mic_data", mic_data, 0);
    checkOutput("rst_pcm_ready", pcm_ready, 1);
    checkOutput("rst_underrun", underrun, 0);
    rst = 1'b0;

    // First rising edge after CLK_DIV enabled edges; left then right
    // first bits are 1 from acc=0, second left bit is 0.
    tick(3);
    checkOutput("pre_rise_clk", mic_clk, 0);
    tick(1);
    checkOutput("first_rise_clk", mic_clk, 1);
    checkOutput("first_left_bit", mic_data, 1);
    tick(4);
    checkOutput("first_fall_clk", mic_clk, 0);
    checkOutput("first_right_bit", mic_data, 1);
    tick(4);
    checkOutput("second_rise_clk", mic_clk, 1);
    checkOutput("second_left_bit", mic_data, 0);

    // Stage (0,0) for window 2, then (+32767,-32768) for window 3.
    applyStimulus(1, 0, 0);
    tick(1);
    applyStimulus(0, 0, 0);
    checkOutput("ready_after_stage", pcm_ready, 0);
    waitBoundary("boundary1_timeout");
    checkOutput("ready_after_boundary", pcm_ready, 1);
    applyStimulus(1, 32767, -32768);
    tick(1);
    applyStimulus(0, 0, 0);
    waitBoundary("boundary2_timeout");
    waitBoundary("boundary3_timeout");
    waitBoundary("boundary4_timeout");
    tick(3);
    checkOutput("window_count", winLQ.size(), 4);
    checkOutput("w1_left_ones", winLQ[0], 32);
    checkOutput("w1_right_ones", winRQ[0], 32);
    checkOutput("w2_left_ones", winLQ[1], 32);
    checkOutput("w2_right_ones", winRQ[1], 32);
    checkOutput("w3_left_ones", winLQ[2], 63);
    checkOutput("w3_right_ones", winRQ[2], 1);
    checkOutput("w4_left_ones", winLQ[3], 64);
    checkOutput("w4_right_ones", winRQ[3], 0);
    checkOutput("underrun_pulses", underrunCnt, 2);

    // pcm_valid held high with a new pair after every accept.
    pairIdx = 0;
    applyStimulus(1, pairL(pairIdx), pairR(pairIdx));
    tick(1);
    checkOutput("ready_after_first_accept", pcm_ready, 0);
    pairIdx++;
    applyStimulus(1, pairL(pairIdx), pairR(pairIdx));
    hsCount = 0;
    bounds = 0;
    budget = 0;
    while (bounds < 4 && budget < 3000) begin
      tick(1);
      budget++;
      if (mAccept) begin
        if (bounds > 0) hsCount++;
        pairIdx++;
        applyStimulus(1, pairL(pairIdx), pairR(pairIdx));
      end
      if (mBound) begin
        bounds++;
        checkOutput("ready_reassert", pcm_ready, 1);
      end
    end
    applyStimulus(0, 0, 0);
    checkOutput("held_boundaries", bounds, 4);
    checkOutput("pairs_per_three_windows", hsCount, 3);

    // Drop enable mid-window, stage a pair while stopped, re-enable.
    tick(37);
    enable = 1'b0;
    tick(1);
    checkOutput("disable_mic_clk", mic_clk, 0);
    checkOutput("disable_mic_data", mic_data, 0);
    checkOutput("disable_ready", pcm_ready, 1);
    applyStimulus(1, 1234, -4321);
    tick(1);
    applyStimulus(0, 0, 0);
    checkOutput("disabled_stage_ready", pcm_ready, 0);
    tick(18);
    enable = 1'b1;
    tick(3);
    checkOutput("reenable_pre_rise", mic_clk, 0);
    tick(1);
    checkOutput("reenable_rise", mic_clk, 1);
    checkOutput("reenable_left_bit", mic_data, 1);
    tick(4);
    checkOutput("reenable_fall", mic_clk, 0);
    checkOutput("reenable_right_bit", mic_data, 1);

    // Asynchronous reset while mic_clk is high and staging is full.
    budget = 0;
    while (mic_clk !== 1'b1 && budget < 20) begin
      tick(1);
      budget++;
    end
    checkOutput("wait_mic_clk_high", mic_clk, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_mic_clk", mic_clk, 0);
    checkOutput("async_rst_mic_data", mic_data, 0);
    checkOutput("async_rst_ready", pcm_ready, 1);
    checkOutput("async_rst_underrun", underrun, 0);
    tick(3);
    rst = 1'b0;

    // After reset the active pair is zero and nothing is staged.
    urBefore = underrunCnt;
    waitBoundary("post_reset_boundary_timeout");
    tick(2);
    checkOutput("post_rst_left_ones", winLQ[winLQ.size()-1], 32);
    checkOutput("post_rst_right_ones", winRQ[winRQ.size()-1], 32);
    checkOutput("post_rst_underrun", underrunCnt - urBefore, 1);

    tick(4);
    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
